// File: rtl/fetch_control_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_control_if
//  Purpose  : Bundles the fetch-stage control signals exchanged between the
//             fetch sequencer (slave side) and its surroundings: hazard unit,
//             MEM-stage branch resolution, instruction memory and IF/ID
//             register (master side).
//  Signals  : stall, branch_taken, branch_target, imem_ready   -> sequencer
//             pc, pc_plus4, PCSrc, pc_write, if_id_write,
//             if_id_flush, fetch_valid, misalign_err           <- sequencer
//  Revision : 1.0 - initial release
// ============================================================================
interface fetch_control_if;
  // Requests into the sequencer
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_ready;

  // Sequencer results
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        PCSrc;
  logic        pc_write;
  logic        if_id_write;
  logic        if_id_flush;
  logic        fetch_valid;
  logic        misalign_err;

  // Pipeline / hazard side: drives requests, observes the sequencer
  modport master (
    output stall, branch_taken, branch_target, imem_ready,
    input  pc, pc_plus4, PCSrc, pc_write, if_id_write, if_id_flush,
           fetch_valid, misalign_err
  );

  // Sequencer side
  modport slave (
    input  stall, branch_taken, branch_target, imem_ready,
    output pc, pc_plus4, PCSrc, pc_write, if_id_write, if_id_flush,
           fetch_valid, misalign_err
  );
endinterface
`default_nettype wire

// File: rtl/fetch_control.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_control
//  Purpose  : Instruction-fetch sequencer. Owns the program counter and
//             drives the fetch-mux select and write enables. Arbitrates
//             branch redirects (highest priority), hazard stalls and
//             instruction-memory wait states, and inserts FLUSH_CYCLES
//             bubble cycles after every taken branch.
//  Params   : RESET_PC     - PC loaded on reset
//             FLUSH_CYCLES - bubble cycles after a redirect (0..7)
//  Ports    : clk   - rising-edge clock
//             reset - asynchronous, active-high reset
//             bus   - fetch_control_if.slave (requests in, PC/control out)
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_control #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  wire logic             clk,
  input  wire logic             reset,
  fetch_control_if.slave        bus
);

  typedef enum logic [1:0] {
    RST_WAIT = 2'd0,
    FETCH    = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q,   cnt_d;
  logic [31:0] pc_q,    pc_d;
  // Last driven fetch_valid, so a stall can hold it
  logic        fv_q,    fv_d;
  logic        mis_q,   mis_d;

  logic        redirect;
  logic        pcsrc;
  logic        pc_write;
  logic        if_id_write;
  logic        if_id_flush;
  logic        fetch_valid;
  logic [31:0] pc_plus4;
  logic [31:0] target_aligned;

  assign pc_plus4       = pc_q + 32'd4;   // wraps naturally at 2^32
  assign target_aligned = {bus.branch_target[31:2], 2'b00};

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    redirect    = 1'b0;
    pcsrc       = 1'b0;
    pc_write    = 1'b0;
    if_id_write = 1'b0;
    if_id_flush = 1'b0;
    fetch_valid = 1'b0;

    case (state_q)
      RST_WAIT: begin
        // Branch requests are ignored while the pipeline comes out of reset
        state_d = FETCH;
      end

      FETCH: begin
        if (bus.branch_taken) begin
          redirect = 1'b1;
        end else if (bus.stall) begin
          fetch_valid = fv_q;
        end else if (!bus.imem_ready) begin
          if_id_write = 1'b1;       // load a bubble while memory waits
        end else begin
          pc_write    = 1'b1;
          if_id_write = 1'b1;
          fetch_valid = 1'b1;
        end
      end

      FLUSH: begin
        if (bus.branch_taken) begin
          redirect = 1'b1;
        end else begin
          // Stall is deliberately not looked at: bubbles are inserted anyway
          if_id_write = 1'b1;
          if_id_flush = 1'b1;
          if (cnt_q <= 3'd1) begin
            state_d = FETCH;
            cnt_d   = 3'd0;
          end else begin
            cnt_d   = cnt_q - 3'd1;
          end
        end
      end

      default: begin
        state_d = RST_WAIT;
        cnt_d   = 3'd0;
      end
    endcase

    // A redirect overrides stall and memory wait from either live state
    if (redirect) begin
      pcsrc       = 1'b1;
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      if_id_flush = 1'b1;
      fetch_valid = 1'b0;
      if (FLUSH_CYCLES > 0) begin
        state_d = FLUSH;
        cnt_d   = FLUSH_LOAD;
      end else begin
        state_d = FETCH;
        cnt_d   = 3'd0;
      end
    end
  end

  always_comb begin
    pc_d = pc_q;
    if (pc_write) begin
      pc_d = pcsrc ? target_aligned : pc_plus4;
    end
  end

  assign fv_d  = fetch_valid;
  assign mis_d = mis_q | (redirect & (|bus.branch_target[1:0]));

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RST_WAIT;
      cnt_q   <= 3'd0;
      pc_q    <= RESET_PC;
      fv_q    <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      fv_q    <= fv_d;
      mis_q   <= mis_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.pc           = pc_q;
  assign bus.pc_plus4     = pc_plus4;
  assign bus.PCSrc        = pcsrc;
  assign bus.pc_write     = pc_write;
  assign bus.if_id_write  = if_id_write;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.fetch_valid  = fetch_valid;
  assign bus.misalign_err = mis_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_control.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_control
//  Purpose  : Self-checking bench for fetch_control (RESET_PC = 0x40,
//             FLUSH_CYCLES = 2). A per-cycle vector table covers normal
//             fetch, redirects, flush, stall, memory wait, wrap-around and
//             misaligned targets; a hand sequence covers reset mid-FLUSH.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_control;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fetch_control_if bus ();

  fetch_control #(
    .RESET_PC     (32'h0000_0040),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        st;
    logic        bt;
    logic [31:0] tgt;
    logic        im;
    logic [31:0] pc;
    logic        src;
    logic        pw;
    logic        ifw;
    logic        fl;
    logic        fv;
    logic        mis;
  } vec_t;

  localparam int NV = 31;
  vec_t vecs [NV];

  function automatic vec_t mk(logic st, logic bt, logic [31:0] tgt, logic im,
                              logic [31:0] pc, logic src, logic pw, logic ifw,
                              logic fl, logic fv, logic mis);
    vec_t v;
    v.st = st; v.bt = bt; v.tgt = tgt; v.im = im; v.pc = pc;
    v.src = src; v.pw = pw; v.ifw = ifw; v.fl = fl; v.fv = fv; v.mis = mis;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic src,
                         input logic pw, input logic ifw, input logic fl,
                         input logic fv, input logic mis);
    chk({tag, " pc"},           bus.pc,                   pc);
    chk({tag, " pc_plus4"},     bus.pc_plus4,             pc + 32'd4);
    chk({tag, " PCSrc"},        32'(bus.PCSrc),           32'(src));
    chk({tag, " pc_write"},     32'(bus.pc_write),        32'(pw));
    chk({tag, " if_id_write"},  32'(bus.if_id_write),     32'(ifw));
    chk({tag, " if_id_flush"},  32'(bus.if_id_flush),     32'(fl));
    chk({tag, " fetch_valid"},  32'(bus.fetch_valid),     32'(fv));
    chk({tag, " misalign_err"}, 32'(bus.misalign_err),    32'(mis));
  endtask

  task automatic drive(input logic st, input logic bt, input logic [31:0] tgt, input logic im);
    bus.stall         = st;
    bus.branch_taken  = bt;
    bus.branch_target = tgt;
    bus.imem_ready    = im;
  endtask

  initial begin
    //                 st bt tgt           im  pc            src pw ifw fl fv mis
    vecs[0]  = mk(0, 1, 32'h300,      1, 32'h40,       0, 0, 0, 0, 0, 0); // RST_WAIT ignores branch
    vecs[1]  = mk(0, 0, 32'h0,        1, 32'h40,       0, 1, 1, 0, 1, 0);
    vecs[2]  = mk(0, 0, 32'h0,        1, 32'h44,       0, 1, 1, 0, 1, 0);
    vecs[3]  = mk(0, 1, 32'h100,      1, 32'h48,       1, 1, 1, 1, 0, 0); // redirect
    vecs[4]  = mk(1, 0, 32'h0,        1, 32'h100,      0, 0, 1, 1, 0, 0); // stall ignored in FLUSH
    vecs[5]  = mk(0, 0, 32'h0,        1, 32'h100,      0, 0, 1, 1, 0, 0);
    vecs[6]  = mk(0, 0, 32'h0,        1, 32'h100,      0, 1, 1, 0, 1, 0); // first valid from target
    vecs[7]  = mk(0, 0, 32'h0,        0, 32'h104,      0, 0, 1, 0, 0, 0); // imem wait bubble
    vecs[8]  = mk(1, 0, 32'h0,        1, 32'h104,      0, 0, 0, 0, 0, 0); // stall holds fv=0
    vecs[9]  = mk(0, 0, 32'h0,        1, 32'h104,      0, 1, 1, 0, 1, 0);
    vecs[10] = mk(1, 0, 32'h0,        1, 32'h108,      0, 0, 0, 0, 1, 0); // stall holds fv=1
    vecs[11] = mk(0, 1, 32'h20,       1, 32'h108,      1, 1, 1, 1, 0, 0);
    vecs[12] = mk(0, 0, 32'h0,        1, 32'h20,       0, 0, 1, 1, 0, 0);
    vecs[13] = mk(0, 0, 32'h0,        1, 32'h20,       0, 0, 1, 1, 0, 0);
    vecs[14] = mk(1, 0, 32'h0,        1, 32'h20,       0, 0, 0, 0, 0, 0); // 3-cycle stall
    vecs[15] = mk(1, 0, 32'h0,        1, 32'h20,       0, 0, 0, 0, 0, 0);
    vecs[16] = mk(1, 0, 32'h0,        1, 32'h20,       0, 0, 0, 0, 0, 0);
    vecs[17] = mk(0, 0, 32'h0,        1, 32'h20,       0, 1, 1, 0, 1, 0);
    vecs[18] = mk(0, 1, 32'hFFFF_FFFC,1, 32'h24,       1, 1, 1, 1, 0, 0);
    vecs[19] = mk(0, 0, 32'h0,        1, 32'hFFFF_FFFC,0, 0, 1, 1, 0, 0);
    vecs[20] = mk(0, 0, 32'h0,        1, 32'hFFFF_FFFC,0, 0, 1, 1, 0, 0);
    vecs[21] = mk(0, 0, 32'h0,        1, 32'hFFFF_FFFC,0, 1, 1, 0, 1, 0);
    vecs[22] = mk(0, 1, 32'h100,      1, 32'h0,        1, 1, 1, 1, 0, 0); // wrapped, no error
    vecs[23] = mk(0, 1, 32'h200,      1, 32'h100,      1, 1, 1, 1, 0, 0); // redirect in FLUSH
    vecs[24] = mk(0, 0, 32'h0,        1, 32'h200,      0, 0, 1, 1, 0, 0);
    vecs[25] = mk(0, 0, 32'h0,        1, 32'h200,      0, 0, 1, 1, 0, 0);
    vecs[26] = mk(1, 1, 32'h203,      0, 32'h200,      1, 1, 1, 1, 0, 0); // all three at once
    vecs[27] = mk(0, 0, 32'h0,        1, 32'h200,      0, 0, 1, 1, 0, 1);
    vecs[28] = mk(0, 0, 32'h0,        1, 32'h200,      0, 0, 1, 1, 0, 1);
    vecs[29] = mk(0, 0, 32'h0,        1, 32'h200,      0, 1, 1, 0, 1, 1);
    vecs[30] = mk(0, 0, 32'h0,        1, 32'h204,      0, 1, 1, 0, 1, 1);

    // Reset: outputs must be quiet even with requests present
    reset = 1'b1;
    drive(0, 1, 32'h300, 1);
    @(negedge clk);
    #2;
    chk_all("reset", 32'h40, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].st, vecs[i].bt, vecs[i].tgt, vecs[i].im);
      #2;
      chk_all($sformatf("row%0d", i), vecs[i].pc, vecs[i].src, vecs[i].pw,
              vecs[i].ifw, vecs[i].fl, vecs[i].fv, vecs[i].mis);
      @(negedge clk);
    end

    // Reset asserted in the middle of a FLUSH sequence
    drive(0, 1, 32'h400, 1);
    #2;
    chk_all("seq redirect", 32'h208, 1, 1, 1, 1, 0, 1);
    @(negedge clk);
    drive(0, 0, 32'h0, 1);
    #1;
    chk_all("seq flush", 32'h400, 0, 0, 1, 1, 0, 1);
    #1;
    reset = 1'b1;
    #1;
    chk_all("seq async reset", 32'h40, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #2;
    chk_all("seq reset held", 32'h40, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    #2;
    chk_all("seq rst_wait", 32'h40, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #2;
    chk_all("seq fetch0", 32'h40, 0, 1, 1, 0, 1, 0);
    @(negedge clk);
    #2;
    chk_all("seq fetch1", 32'h44, 0, 1, 1, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_control.md
# fetch_control

Sequencer for the instruction-fetch stage: owns the program counter register and drives the next-PC select and write enables around the fetch mux (PC+4 vs branch target). It arbitrates between branch redirects, hazard stalls and instruction-memory wait states, and it inserts a programmable number of flush bubbles after every taken branch. It sits between the hazard unit / MEM-stage branch resolution and the IF/ID pipeline register.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `FLUSH_CYCLES`, 1: extra bubble cycles after a redirect, legal range 0–7.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset.
- `stall` in 1: hazard-unit hold request.
- `branch_taken` in 1: taken branch resolved this cycle.
- `branch_target` in 32: redirect address, valid when `branch_taken`=1.
- `imem_ready` in 1: instruction memory returns the word for `pc` this cycle.
- `pc` out 32: current fetch address (registered).
- `pc_plus4` out 32: `pc`+4, modulo 2^32 (feeds the mux add input).
- `PCSrc` out 1: fetch mux select; 1 selects the branch target.
- `pc_write` out 1: PC advances at the next edge.
- `if_id_write` out 1: IF/ID register load enable.
- `if_id_flush` out 1: IF/ID register clear.
- `fetch_valid` out 1: the IF/ID contents being loaded are a real instruction.
- `misalign_err` out 1: sticky; set when a target with bits [1:0]≠0 is taken.

## Operation
- States: RST_WAIT, FETCH, FLUSH.
- RST_WAIT is entered on reset and lasts exactly one cycle after `reset` deasserts. `pc_write`=0 and `fetch_valid`=0. It then moves to FETCH. `branch_taken` is ignored in this state.
- FETCH, priority order (highest first):
  - `branch_taken`: `PCSrc`=1, `pc_write`=1, `if_id_flush`=1, `fetch_valid`=0. Next `pc` = {`branch_target`[31:2], 2'b00}. If `FLUSH_CYCLES`>0, go to FLUSH with the counter loaded with `FLUSH_CYCLES`; otherwise stay in FETCH.
  - `stall`: `pc_write`=0, `if_id_write`=0, and `fetch_valid` holds its last value.
  - `!imem_ready`: `pc_write`=0, `if_id_write`=1, `fetch_valid`=0 (bubble).
  - Otherwise: `pc_write`=1, `PCSrc`=0, `if_id_write`=1, `fetch_valid`=1. Next `pc` = `pc_plus4`.
- FLUSH:
  - `pc_write`=0, `if_id_write`=1, `if_id_flush`=1, `fetch_valid`=0.
  - The counter decrements each cycle. When it reaches 1, the next state is FETCH.
  - A `branch_taken` in FLUSH redirects again, applying the same outputs as a redirect in FETCH, and reloads the counter. `stall` has no effect in FLUSH.
- A misaligned target sets `misalign_err` at the redirect edge. It stays set until reset.
- `PCSrc`=0 whenever no redirect is taking place in the current cycle.
- Wrap-around: when `pc`=32'hFFFF_FFFC, `pc_plus4`=32'h0000_0000. No error is flagged.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, state=RST_WAIT, counter=0, `misalign_err`=0.
  - `pc_write`, `PCSrc`, `if_id_write`, `if_id_flush` and `fetch_valid` are all 0 while `reset`=1.
- `pc` updates only on the rising edge, and only when `pc_write`=1.
- All other outputs are combinational from the state, the counter and the current inputs.
- Redirect latency: target is visible on `pc` one cycle after `branch_taken`. The first valid fetch from the target comes `FLUSH_CYCLES`+1 cycles after `branch_taken`, provided `imem_ready`=1 and `stall`=0.
- Simultaneous `branch_taken`, `stall` and `!imem_ready`: the redirect wins and PC is written.
- Asserting `reset` mid-FLUSH or mid-stall immediately forces reset values; the pending redirect is discarded.

## Test plan
- Reset release, `RESET_PC`=32'h0000_0040, `imem_ready`=1: `pc` reads 0x40 for 2 cycles, then 0x44, then 0x48. `fetch_valid` first goes to 1 in cycle 2.
- `branch_taken` with target 0x100 at `pc`=0x48, `FLUSH_CYCLES`=2: `PCSrc`=1 and `if_id_flush`=1 on the redirect cycle. Next `pc`=0x100, held for 2 flush cycles, then 0x104.
- `stall` held 3 cycles at `pc`=0x20: `pc` stays 0x20 and `if_id_write`=0 for 3 cycles. Advances to 0x24 on the 4th cycle.
- Simultaneous `stall`=1, `imem_ready`=0, `branch_taken`=1 with target 0x203: `pc` becomes 0x200 and `misalign_err`=1 until reset.
- `pc`=0xFFFF_FFFC with `imem_ready`=1: next `pc`=0x0000_0000 and `misalign_err` stays 0.
- `reset` pulsed during FLUSH with counter=2: `pc`=`RESET_PC` immediately, all control outputs are 0, and the FSM restarts from RST_WAIT.
